sap_microsequencer: RTL and testbench

- Parametrised, variable-length microcode sequencer for the SAP CPU datapath; replaces the fixed six-stage controller.
- Decodes the 4-bit IR opcode into a registered control word that drives the PC, MAR/RAM, IR, A, B, adder, output register and flags register.
- Additions over the fixed controller:
  - instructions end early instead of always spending six stages;
  - STA, LDI, JMP, JC, JZ and OUT opcodes;
  - conditional jumps on flags;
  - a sticky halt;
  - a single-instruction step mode.

---
 rtl/sap_microsequencer.sv | 198 +++++++++++++++++++
 tb/tb_sap_microsequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_microsequencer.sv
// sap_microsequencer
// Variable-length microcode sequencer for the SAP CPU datapath. Decodes the
// IR opcode into a registered control word, ends each instruction on its last
// micro-step, supports conditional jumps, a sticky halt and single-step mode.
// The control word lags stage_o by one cycle: each edge registers the word
// for the current stage and advances the stage at the same time.

module sap_microsequencer #(
    parameter int CW_W          = 16,
    parameter int STAGE_W       = 3,
    parameter int JUMP_ON_FLAGS = 1,
    parameter int STEP_EN       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         opcode,
    input  logic               flag_c,
    input  logic               flag_z,
    input  logic               step_mode,
    input  logic               step,
    output logic [CW_W-1:0]    out,
    output logic [STAGE_W-1:0] stage_o,
    output logic               instr_done,
    output logic               halted
);

    // Control word bits
    localparam logic [15:0] HLT        = 16'h8000;
    localparam logic [15:0] PC_INC     = 16'h4000;
    localparam logic [15:0] PC_EN      = 16'h2000;
    localparam logic [15:0] PC_LOAD    = 16'h1000;
    localparam logic [15:0] MAR_LOAD   = 16'h0800;
    localparam logic [15:0] MEM_EN     = 16'h0400;
    localparam logic [15:0] RAM_WE     = 16'h0200;
    localparam logic [15:0] IR_LOAD    = 16'h0100;
    localparam logic [15:0] IR_EN      = 16'h0080;
    localparam logic [15:0] A_LOAD     = 16'h0040;
    localparam logic [15:0] A_EN       = 16'h0020;
    localparam logic [15:0] B_LOAD     = 16'h0010;
    localparam logic [15:0] ADDER_SUB  = 16'h0008;
    localparam logic [15:0] ADDER_EN   = 16'h0004;
    localparam logic [15:0] OUT_LOAD   = 16'h0002;
    localparam logic [15:0] FLAGS_LOAD = 16'h0001;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [STAGE_W-1:0]  r_stage;
    logic [STAGE_W-1:0]  w_nextStage;
    logic [CW_W-1:0]     r_out;
    logic [CW_W-1:0]     w_nextOut;
    logic                r_done;
    logic                w_nextDone;

    logic [15:0]         w_word;
    logic                w_last;
    logic                w_isHlt;
    logic                w_takeC;
    logic                w_takeZ;
    logic                w_pause;

    assign w_takeC = (JUMP_ON_FLAGS != 0) && flag_c;
    assign w_takeZ = (JUMP_ON_FLAGS != 0) && flag_z;
    assign w_pause = (STEP_EN != 0) && step_mode && !step && (r_stage == '0);

    // Microcode decode: control word and last-step flag for the current stage
    always_comb begin
        w_word  = 16'h0000;
        w_last  = 1'b0;
        w_isHlt = 1'b0;
        case (r_stage)
            STAGE_W'(0): w_word = PC_EN | MAR_LOAD;
            STAGE_W'(1): w_word = PC_INC;
            STAGE_W'(2): w_word = MEM_EN | IR_LOAD;
            STAGE_W'(3): begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w_word = IR_EN | MAR_LOAD;
                    OP_LDI: begin
                        w_word = IR_EN | A_LOAD;
                        w_last = 1'b1;
                    end
                    OP_JMP: begin
                        w_word = IR_EN | PC_LOAD;
                        w_last = 1'b1;
                    end
                    OP_JC: begin
                        w_word = w_takeC ? (IR_EN | PC_LOAD) : 16'h0000;
                        w_last = 1'b1;
                    end
                    OP_JZ: begin
                        w_word = w_takeZ ? (IR_EN | PC_LOAD) : 16'h0000;
                        w_last = 1'b1;
                    end
                    OP_OUT: begin
                        w_word = A_EN | OUT_LOAD;
                        w_last = 1'b1;
                    end
                    OP_HLT: begin
                        w_word  = HLT;
                        w_last  = 1'b1;
                        w_isHlt = 1'b1;
                    end
                    default: w_last = 1'b1;
                endcase
            end
            STAGE_W'(4): begin
                case (opcode)
                    OP_LDA: begin
                        w_word = MEM_EN | A_LOAD;
                        w_last = 1'b1;
                    end
                    OP_ADD, OP_SUB: w_word = MEM_EN | B_LOAD;
                    OP_STA: begin
                        w_word = A_EN | RAM_WE;
                        w_last = 1'b1;
                    end
                    default: w_last = 1'b1;
                endcase
            end
            STAGE_W'(5): begin
                w_last = 1'b1;
                case (opcode)
                    OP_ADD:  w_word = ADDER_EN | A_LOAD | FLAGS_LOAD;
                    OP_SUB:  w_word = ADDER_EN | ADDER_SUB | A_LOAD | FLAGS_LOAD;
                    default: w_word = 16'h0000;
                endcase
            end
            default: w_last = 1'b1;
        endcase
    end

    // State register: halt state, stage counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_stage <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_stage <= w_nextStage;
            r_out   <= w_nextOut;
            r_done  <= w_nextDone;
        end
    end

    // Next-state logic: freeze when halted, hold at T0 while paused, wrap at the last step
    always_comb begin
        w_nextState = r_state;
        w_nextStage = r_stage;
        if (r_state == ST_HALT) begin
            w_nextStage = r_stage;
        end else if (w_pause) begin
            w_nextStage = '0;
        end else if (w_isHlt) begin
            w_nextState = ST_HALT;
            w_nextStage = r_stage;
        end else if (w_last) begin
            w_nextStage = '0;
        end else begin
            w_nextStage = r_stage + STAGE_W'(1);
        end
    end

    // Output logic: next control word and end-of-instruction strobe
    always_comb begin
        w_nextOut  = '0;
        w_nextDone = 1'b0;
        if (r_state == ST_HALT) begin
            w_nextOut = CW_W'(HLT);
        end else if (!w_pause) begin
            w_nextOut  = CW_W'(w_word);
            w_nextDone = w_last && !w_isHlt;
        end
    end

    assign out        = r_out;
    assign stage_o    = r_stage;
    assign instr_done = r_done;
    assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_sap_microsequencer.sv
// tb_sap_microsequencer
// Scoreboard bench: each scenario pushes the expected control words for the
// cycles it drives, then pops and compares them one per clock. A second
// instance with JUMP_ON_FLAGS=0 shares the inputs for the JZ case.

module tb_sap_microsequencer;

    typedef struct {
        logic [15:0] word;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [15:0] out;
    logic [2:0]  stage_o;
    logic        instr_done;
    logic        halted;
    logic [15:0] out2;
    logic [2:0]  stage2;
    logic        done2;
    logic        halted2;

    exp_t q[$];
    int   passCount = 0;
    int   checkCount = 0;

    sap_microsequencer #(.CW_W(16), .STAGE_W(3), .JUMP_ON_FLAGS(1), .STEP_EN(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .step_mode(step_mode), .step(step), .out(out), .stage_o(stage_o),
        .instr_done(instr_done), .halted(halted)
    );

    sap_microsequencer #(.CW_W(16), .STAGE_W(3), .JUMP_ON_FLAGS(0), .STEP_EN(1)) dutNoJump (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .step_mode(step_mode), .step(step), .out(out2), .stage_o(stage2),
        .instr_done(done2), .halted(halted2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task pushExp(input logic [15:0] w, input logic d);
        exp_t e;
        e.word = w;
        e.done = d;
        q.push_back(e);
    endtask

    task pushFetch();
        pushExp(16'h2800, 1'b0);
        pushExp(16'h4000, 1'b0);
        pushExp(16'h0500, 1'b0);
    endtask

    // Pulse reset across one negedge-to-negedge window and drop stale expectations
    task applyStimulus();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (out !== 16'h0000) $display("[TB] FAIL reset_out: got %h want 0000", out);
        else passCount++;
        checkCount++;
        if (stage_o !== 3'd0) $display("[TB] FAIL reset_stage: got %0d want 0", stage_o);
        else passCount++;
        checkCount++;
        if (instr_done !== 1'b0 || halted !== 1'b0)
            $display("[TB] FAIL reset_flags: done=%b halted=%b want 0 0", instr_done, halted);
        else passCount++;
        checkCount++;
        if (out2 !== 16'h0000 || halted2 !== 1'b0)
            $display("[TB] FAIL reset_nojump: out=%h halted=%b want 0000 0", out2, halted2);
        else passCount++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_lda();
        exp_t e;
        opcode = 4'h0;
        applyStimulus();
        pushFetch();
        pushExp(16'h0880, 1'b0);
        pushExp(16'h0440, 1'b1);
        pushExp(16'h2800, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (q.size() == 0) $display("[TB] FAIL lda_cycle%0d: scoreboard empty", i);
            else begin
                e = q.pop_front();
                if (out !== e.word || instr_done !== e.done)
                    $display("[TB] FAIL lda_cycle%0d: out=%h done=%b want %h %b", i, out, instr_done, e.word, e.done);
                else passCount++;
            end
        end
        checkCount++;
        if (stage_o !== 3'd1) $display("[TB] FAIL lda_wrap_stage: got %0d want 1", stage_o);
        else passCount++;
    endtask

    task test_add_sub();
        exp_t e;
        opcode = 4'h1;
        applyStimulus();
        pushFetch();
        pushExp(16'h0880, 1'b0);
        pushExp(16'h0410, 1'b0);
        pushExp(16'h0045, 1'b1);
        pushFetch();
        pushExp(16'h0880, 1'b0);
        pushExp(16'h0410, 1'b0);
        pushExp(16'h004D, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (q.size() == 0) $display("[TB] FAIL addsub_cycle%0d: scoreboard empty", i);
            else begin
                e = q.pop_front();
                if (out !== e.word || instr_done !== e.done)
                    $display("[TB] FAIL addsub_cycle%0d: out=%h done=%b want %h %b", i, out, instr_done, e.word, e.done);
                else passCount++;
            end
            if (i == 5) opcode = 4'h2;
        end
    endtask

    task test_jumps();
        exp_t e;
        opcode = 4'h6;
        flag_c = 1'b0;
        applyStimulus();
        pushFetch();
        pushExp(16'h0000, 1'b1);
        pushFetch();
        pushExp(16'h1080, 1'b1);
        pushFetch();
        pushExp(16'h1080, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (q.size() == 0) $display("[TB] FAIL jump_cycle%0d: scoreboard empty", i);
            else begin
                e = q.pop_front();
                if (out !== e.word || instr_done !== e.done)
                    $display("[TB] FAIL jump_cycle%0d: out=%h done=%b want %h %b", i, out, instr_done, e.word, e.done);
                else passCount++;
            end
            if (i == 3) flag_c = 1'b1;
            if (i == 7) begin
                opcode = 4'h7;
                flag_c = 1'b0;
                flag_z = 1'b1;
            end
            if (i == 11) begin
                checkCount++;
                if (out2 !== 16'h0000 || done2 !== 1'b1)
                    $display("[TB] FAIL jz_nojump: out=%h done=%b want 0000 1", out2, done2);
                else passCount++;
            end
        end
        flag_z = 1'b0;
    endtask

    task test_halt();
        exp_t e;
        opcode = 4'hF;
        applyStimulus();
        pushFetch();
        pushExp(16'h8000, 1'b0);
        for (int i = 0; i < 20; i++) pushExp(16'h8000, 1'b0);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (q.size() == 0) $display("[TB] FAIL halt_cycle%0d: scoreboard empty", i);
            else begin
                e = q.pop_front();
                if (out !== e.word || instr_done !== e.done)
                    $display("[TB] FAIL halt_cycle%0d: out=%h done=%b want %h %b", i, out, instr_done, e.word, e.done);
                else passCount++;
            end
            if (i == 3) begin
                checkCount++;
                if (halted !== 1'b1) $display("[TB] FAIL halt_set: halted=%b want 1", halted);
                else passCount++;
            end
        end
        checkCount++;
        if (stage_o !== 3'd3 || halted !== 1'b1)
            $display("[TB] FAIL halt_frozen: stage=%0d halted=%b want 3 1", stage_o, halted);
        else passCount++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkCount++;
        if (out !== 16'h0000 || halted !== 1'b0 || stage_o !== 3'd0 || instr_done !== 1'b0)
            $display("[TB] FAIL halt_clear: out=%h halted=%b stage=%0d done=%b want 0000 0 0 0", out, halted, stage_o, instr_done);
        else passCount++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_step();
        exp_t e;
        opcode = 4'h4;
        step_mode = 1'b1;
        step = 1'b0;
        applyStimulus();
        for (int i = 0; i < 10; i++) pushExp(16'h0000, 1'b0);
        pushFetch();
        pushExp(16'h00C0, 1'b1);
        pushExp(16'h0000, 1'b0);
        pushExp(16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (q.size() == 0) $display("[TB] FAIL step_cycle%0d: scoreboard empty", i);
            else begin
                e = q.pop_front();
                if (out !== e.word || instr_done !== e.done)
                    $display("[TB] FAIL step_cycle%0d: out=%h done=%b want %h %b", i, out, instr_done, e.word, e.done);
                else passCount++;
            end
            if (i == 9) begin
                checkCount++;
                if (stage_o !== 3'd0) $display("[TB] FAIL step_paused_stage: got %0d want 0", stage_o);
                else passCount++;
                step = 1'b1;
            end
            if (i == 10) step = 1'b0;
        end
        checkCount++;
        if (stage_o !== 3'd0) $display("[TB] FAIL step_repause_stage: got %0d want 0", stage_o);
        else passCount++;
        step_mode = 1'b0;
    endtask

    task test_async_reset();
        exp_t e;
        opcode = 4'h1;
        applyStimulus();
        pushFetch();
        pushExp(16'h0880, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (q.size() == 0) $display("[TB] FAIL arst_cycle%0d: scoreboard empty", i);
            else begin
                e = q.pop_front();
                if (out !== e.word || instr_done !== e.done)
                    $display("[TB] FAIL arst_cycle%0d: out=%h done=%b want %h %b", i, out, instr_done, e.word, e.done);
                else passCount++;
            end
        end
        checkCount++;
        if (stage_o !== 3'd4) $display("[TB] FAIL arst_in_t4: stage=%0d want 4", stage_o);
        else passCount++;
        #3 rst = 1'b1;
        #1;
        checkCount++;
        if (out !== 16'h0000 || stage_o !== 3'd0)
            $display("[TB] FAIL arst_immediate: out=%h stage=%0d want 0000 0", out, stage_o);
        else passCount++;
        #2 rst = 1'b0;
        q.delete();
        pushExp(16'h2800, 1'b0);
        @(posedge clk); #1;
        checkCount++;
        if (q.size() == 0) $display("[TB] FAIL arst_restart: scoreboard empty");
        else begin
            e = q.pop_front();
            if (out !== e.word || instr_done !== e.done)
                $display("[TB] FAIL arst_restart: out=%h done=%b want %h %b", out, instr_done, e.word, e.done);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_jumps();
        test_halt();
        test_step();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
